// File: rtl/param_rd_arbiter.sv
// Round-robin arbiter sharing the param BRAM read port among NUM_REQ rd controllers, one read in flight.
// Latency: addr handshake T -> bram_en T+1 -> rsp_valid T+3; addr ready only in IDLE, rsp held until rsp_ready.
module param_rd_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int PARAM_WIDTH = 64,
    parameter int PARAM_DEPTH = 64,
    parameter int AW          = $clog2(PARAM_DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0][AW-1:0]   req_addr,
    input  logic [NUM_REQ-1:0]           req_addr_valid,
    output logic [NUM_REQ-1:0]           req_addr_ready,
    output logic [PARAM_WIDTH-1:0]       rsp_data,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic                         rsp_err,
    output logic                         bram_en,
    output logic [AW-1:0]                bram_addr,
    input  logic [PARAM_WIDTH-1:0]       bram_dout,
    output logic                         busy
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [AW-1:0] DEPTH_L = AW'(PARAM_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t                 state_q, state_d;
    logic [GW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]          gnt_q, gnt_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic                   err_q, err_d;
    logic [PARAM_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;

    logic                   found;
    logic [GW-1:0]          gnt_sel;
    logic [GW-1:0]          idx_g;
    int                     sum;
    logic                   in_range;

    // Rotating priority search starting at rr_ptr.
    always_comb begin
        found   = 1'b0;
        gnt_sel = '0;
        idx_g   = '0;
        sum     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = int'(rr_ptr_q) + k;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            idx_g = GW'(sum);
            if (!found && req_addr_valid[idx_g]) begin
                found   = 1'b1;
                gnt_sel = idx_g;
            end
        end
    end

    // The MSB only selects the ping-pong half; range check applies to the word index.
    assign in_range = ({1'b0, addr_q[AW-2:0]} < DEPTH_L);

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        gnt_d          = gnt_q;
        addr_d         = addr_q;
        err_d          = err_q;
        rsp_data_d     = rsp_data_q;
        rsp_err_d      = rsp_err_q;
        rsp_valid_d    = rsp_valid_q;
        req_addr_ready = '0;
        bram_en        = 1'b0;
        bram_addr      = '0;
        case (state_q)
            IDLE: begin
                if (found && !rst) begin
                    req_addr_ready[gnt_sel] = 1'b1;
                    addr_d   = req_addr[gnt_sel];
                    gnt_d    = gnt_sel;
                    rr_ptr_d = (gnt_sel == GW'(NUM_REQ - 1)) ? '0 : gnt_sel + GW'(1);
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (in_range) begin
                    bram_en   = 1'b1;
                    bram_addr = addr_q;
                    err_d     = 1'b0;
                end else begin
                    err_d     = 1'b1;
                end
                state_d = CAPTURE;
            end
            CAPTURE: begin
                rsp_data_d         = err_q ? '0 : bram_dout;
                rsp_err_d          = err_q;
                rsp_valid_d        = '0;
                rsp_valid_d[gnt_q] = 1'b1;
                state_d            = RESP;
            end
            RESP: begin
                if (rsp_ready[gnt_q]) begin
                    rsp_valid_d = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            addr_q      <= '0;
            err_q       <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_param_rd_arbiter.sv
// Directed bench for param_rd_arbiter with a behavioural 1-cycle-latency BRAM.
// PARAM_DEPTH=48 so that an index with the half-select MSB clear can actually be out of range.
module tb_param_rd_arbiter;

    localparam int NR = 4;
    localparam int PW = 64;
    localparam int PD = 48;
    localparam int AW = $clog2(PD) + 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NR-1:0][AW-1:0] req_addr;
    logic [NR-1:0]         req_addr_valid;
    logic [NR-1:0]         req_addr_ready;
    logic [PW-1:0]         rsp_data;
    logic [NR-1:0]         rsp_valid;
    logic [NR-1:0]         rsp_ready;
    logic                  rsp_err;
    logic                  bram_en;
    logic [AW-1:0]         bram_addr;
    logic [PW-1:0]         bram_dout;
    logic                  busy;

    logic [PW-1:0]         mem [0:127];
    int                    errors = 0;
    int                    checks = 0;

    always #5 clk = ~clk;

    param_rd_arbiter #(
        .NUM_REQ(NR), .PARAM_WIDTH(PW), .PARAM_DEPTH(PD), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_addr(req_addr), .req_addr_valid(req_addr_valid), .req_addr_ready(req_addr_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
        .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout), .busy(busy)
    );

    always @(posedge clk) begin
        if (bram_en) bram_dout <= mem[bram_addr];
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Single-requester read from handshake to the first RESP cycle.
    task automatic txn(input int r, input logic [AW-1:0] a, input logic [63:0] d, input bit e);
        logic [63:0] oh;
        oh = 64'(1) << r;
        req_addr[r]    = a;
        req_addr_valid = '0;
        req_addr_valid[r] = 1'b1;
        #1;
        chk("ready_idle", 64'(req_addr_ready), oh);
        chk("busy_idle", 64'(busy), 64'd0);
        tick();
        req_addr_valid = '0;
        #1;
        chk("bram_en_issue", 64'(bram_en), e ? 64'd0 : 64'd1);
        chk("bram_addr_issue", 64'(bram_addr), e ? 64'd0 : 64'(a));
        chk("busy_issue", 64'(busy), 64'd1);
        chk("ready_issue", 64'(req_addr_ready), 64'd0);
        tick();
        chk("rsp_valid_capture", 64'(rsp_valid), 64'd0);
        chk("bram_en_capture", 64'(bram_en), 64'd0);
        tick();
        chk("rsp_valid_resp", 64'(rsp_valid), oh);
        chk("rsp_data_resp", rsp_data, d);
        chk("rsp_err_resp", 64'(rsp_err), 64'(e));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 128; i++) mem[i] = 64'h1000 + 64'(i);
        mem[5]  = 64'hA5A5;
        mem[66] = 64'hBEEF_0042;
        rst = 1'b1; req_addr = '0; req_addr_valid = '0; rsp_ready = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_ready", 64'(req_addr_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_bram_en", 64'(bram_en), 64'd0);
        chk("rst_bram_addr", 64'(bram_addr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        tick();

        // Basic read with one cycle of held response.
        txn(0, 7'd5, 64'hA5A5, 1'b0);
        tick();
        chk("hold_valid", 64'(rsp_valid), 64'h1);
        chk("hold_data", rsp_data, 64'hA5A5);
        rsp_ready = 4'b0001;
        tick();
        chk("release_valid", 64'(rsp_valid), 64'd0);
        chk("release_busy", 64'(busy), 64'd0);

        // Fairness with every requester valid and rsp_ready held high.
        do_reset();
        rsp_ready = '1;
        for (int i = 0; i < NR; i++) req_addr[i] = AW'(10 + i);
        req_addr_valid = '1;
        for (int n = 0; n < 5; n++) begin
            #1;
            chk("rr_grant", 64'(req_addr_ready), 64'(1) << order[n]);
            tick();
            chk("rr_ready_issue", 64'(req_addr_ready), 64'd0);
            chk("rr_bram_addr", 64'(bram_addr), 64'(10 + order[n]));
            tick();
            chk("rr_ready_capture", 64'(req_addr_ready), 64'd0);
            tick();
            chk("rr_ready_resp", 64'(req_addr_ready), 64'd0);
            chk("rr_rsp_valid", 64'(rsp_valid), 64'(1) << order[n]);
            chk("rr_rsp_data", rsp_data, 64'h1000 + 64'(10 + order[n]));
            tick();
        end
        req_addr_valid = '0;

        // Word index 51 >= depth 48 with half-select clear: error response, no BRAM access.
        txn(2, 7'd51, 64'd0, 1'b1);
        tick();
        chk("err_done_busy", 64'(busy), 64'd0);

        // Backpressure on requester 1 while requester 3 waits.
        rsp_ready = '0;
        txn(1, 7'd20, 64'h1014, 1'b0);
        req_addr[3] = 7'd30;
        req_addr_valid = 4'b1000;
        for (int k = 0; k < 10; k++) begin
            rsp_ready = (k % 2 == 1) ? 4'b1101 : 4'b0000;
            #1;
            chk("bp_ready3", 64'(req_addr_ready), 64'd0);
            chk("bp_valid", 64'(rsp_valid), 64'h2);
            chk("bp_data", rsp_data, 64'h1014);
            tick();
        end
        rsp_ready = 4'b0010;
        tick();
        rsp_ready = '1;
        txn(3, 7'd30, 64'h101E, 1'b0);
        tick();

        // Reset during CAPTURE drops the read and clears rr_ptr.
        req_addr[0] = 7'd7;
        req_addr_valid = 4'b0001;
        tick();
        req_addr_valid = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_rsp_data", rsp_data, 64'd0);
        chk("mid_rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("mid_rst_bram_en", 64'(bram_en), 64'd0);
        chk("mid_rst_bram_addr", 64'(bram_addr), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ready", 64'(req_addr_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("dropped_no_rsp", 64'(rsp_valid), 64'd0);
        end
        req_addr_valid = '1;
        #1;
        chk("rr_ptr_after_rst", 64'(req_addr_ready), 64'h1);
        req_addr_valid = '0;
        tick();

        // Upper ping-pong half.
        rsp_ready = 4'b0010;
        txn(1, 7'h42, 64'hBEEF_0042, 1'b0);
        tick();
        chk("upper_done_valid", 64'(rsp_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
